// File: rtl/struct_stream_fifo.sv
// struct_stream_fifo: valid/ready FIFO carrying packed records of DATA_W bits.
// Define STRUCT_STREAM_FIFO_DEDUP_EN to drop pushes that repeat the last stored record.
module struct_stream_fifo #(
  parameter int DATA_W = 96,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} fill_state_t;

  fill_state_t       state_q, state_d;
  logic [DATA_W-1:0] storage [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count_q, count_d;
  logic              push, pop, store;

  // Handshake flags come only from registered state, so out_ready never reaches in_ready.
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = out_valid ? storage[rd_ptr] : '0;
  assign count     = count_q;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

`ifdef STRUCT_STREAM_FIFO_DEDUP_EN
  logic [DATA_W-1:0] last_q;
  logic              hist_valid_q;
  logic [7:0]        drop_q;
  logic              dup;

  // A duplicate is still handshaken, just not written; history follows stores, not pops.
  assign dup   = hist_valid_q && (in_data == last_q);
  assign store = push && !dup;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q       <= '0;
      hist_valid_q <= 1'b0;
      drop_q       <= '0;
    end else begin
      if (store) begin
        last_q       <= in_data;
        hist_valid_q <= 1'b1;
      end
      if (push && dup && (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;
    end
  end

  assign drop_cnt = drop_q;
`else
  assign store    = push;
  assign drop_cnt = '0;
`endif

  always_comb begin
    count_d = count_q;
    state_d = PARTIAL;
    if (store && !pop)
      count_d = count_q + CW'(1);
    else if (!store && pop)
      count_d = count_q - CW'(1);
    if (count_d == '0)
      state_d = EMPTY;
    else if (count_d == FULL_CNT)
      state_d = FULL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      count_q <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (store) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // Storage is not reset; pointers and count alone decide what is valid.
  always_ff @(posedge clk) begin
    if (store) storage[wr_ptr] <= in_data;
  end

endmodule

// File: tb/tb_struct_stream_fifo.sv
// tb_struct_stream_fifo: vector table, corner sequences and randomized traffic against a queue model.
// Honours STRUCT_STREAM_FIFO_DEDUP_EN the same way the design does.
module tb_struct_stream_fifo;

  localparam int DW = 96;
  localparam int DP = 4;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic [2:0]    count;
  logic [7:0]    drop_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: a queue of stored records plus dedup history.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] mlast;
  bit            mhv;
  int            mdrop;

  typedef struct {
    logic          iv;
    logic [DW-1:0] d;
    logic          ordy;
    int            ecount;
    logic          eov;
    logic [DW-1:0] eod;
    logic          eir;
  } vec_t;

  vec_t vecs[9];

  struct_stream_fifo #(.DATA_W(DW), .DEPTH(DP)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .count    (count),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    mlast = '0;
    mhv   = 1'b0;
    mdrop = 0;
  endtask

  task automatic checkOutput(input string tag);
    logic [DW-1:0] head;
    head = (mq.size() != 0) ? mq[0] : '0;
    cmp({tag, ".count"},     DW'(count),     DW'(mq.size()));
    cmp({tag, ".out_valid"}, DW'(out_valid), DW'(mq.size() != 0));
    cmp({tag, ".out_data"},  out_data,       head);
    cmp({tag, ".in_ready"},  DW'(in_ready),  DW'(mq.size() < DP));
    cmp({tag, ".drop_cnt"},  DW'(drop_cnt),  DW'(mdrop));
  endtask

  // Drive one cycle, advance the model at the edge, then compare just after it.
  task automatic applyStimulus(input logic iv, input logic [DW-1:0] d, input logic ordy,
                               input string tag);
    bit mpush, mpop;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    @(posedge clk);
    mpop  = (mq.size() != 0) && ordy;
    mpush = iv && (mq.size() < DP);
    if (mpop) void'(mq.pop_front());
    if (mpush) begin
`ifdef STRUCT_STREAM_FIFO_DEDUP_EN
      if (mhv && d == mlast) begin
        if (mdrop < 255) mdrop++;
      end else begin
        mq.push_back(d);
        mlast = d;
        mhv   = 1'b1;
      end
`else
      mq.push_back(d);
`endif
    end
    #1;
    checkOutput(tag);
  endtask

  // Reset pulse placed strictly between clock edges.
  task automatic pulseReset();
    #2 rst_n = 1'b0;
    #1;
    cmp("rst.count",     DW'(count),     DW'(0));
    cmp("rst.out_valid", DW'(out_valid), DW'(0));
    cmp("rst.out_data",  out_data,       DW'(0));
    cmp("rst.in_ready",  DW'(in_ready),  DW'(1));
    cmp("rst.drop_cnt",  DW'(drop_cnt),  DW'(0));
    modelReset();
    #1 rst_n = 1'b1;
  endtask

  logic [DW-1:0] recA, recB, recC, recD, recE;
  logic [DW-1:0] pool[4];

  initial begin
    recA = 96'h8000_0000_0000_0000_0000_0001;
    recB = 96'h0000_0001_8000_0000_0000_0002;
    recC = 96'hFFFF_FFFF_0000_0000_FFFF_FFFF;
    recD = 96'h1234_5678_9ABC_DEF0_0F0F_F0F0;
    recE = 96'hDEAD_BEEF_CAFE_F00D_0000_0005;

    vecs[0] = '{1'b1, recA, 1'b0, 1, 1'b1, recA, 1'b1};
    vecs[1] = '{1'b1, recB, 1'b0, 2, 1'b1, recA, 1'b1};
    vecs[2] = '{1'b1, recC, 1'b0, 3, 1'b1, recA, 1'b1};
    vecs[3] = '{1'b1, recD, 1'b0, 4, 1'b1, recA, 1'b0};
    vecs[4] = '{1'b1, recE, 1'b0, 4, 1'b1, recA, 1'b0};
    vecs[5] = '{1'b0, '0,   1'b1, 3, 1'b1, recB, 1'b1};
    vecs[6] = '{1'b0, '0,   1'b1, 2, 1'b1, recC, 1'b1};
    vecs[7] = '{1'b0, '0,   1'b1, 1, 1'b1, recD, 1'b1};
    vecs[8] = '{1'b0, '0,   1'b1, 0, 1'b0, '0,   1'b1};

    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    modelReset();
    #1;
    cmp("init.count",     DW'(count),     DW'(0));
    cmp("init.out_valid", DW'(out_valid), DW'(0));
    cmp("init.out_data",  out_data,       DW'(0));
    cmp("init.in_ready",  DW'(in_ready),  DW'(1));
    cmp("init.drop_cnt",  DW'(drop_cnt),  DW'(0));
    #2 rst_n = 1'b1;

    // Fill to full, try one more, then drain in order.
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].iv, vecs[i].d, vecs[i].ordy, $sformatf("vec%0d", i));
      cmp($sformatf("vec%0d.count_c", i),     DW'(count),     DW'(vecs[i].ecount));
      cmp($sformatf("vec%0d.out_valid_c", i), DW'(out_valid), DW'(vecs[i].eov));
      cmp($sformatf("vec%0d.out_data_c", i),  out_data,       vecs[i].eod);
      cmp($sformatf("vec%0d.in_ready_c", i),  DW'(in_ready),  DW'(vecs[i].eir));
    end

    // Steady push+pop at count 2 walks both pointers around the ring.
    applyStimulus(1'b1, 96'h100, 1'b0, "wrap.fill0");
    applyStimulus(1'b1, 96'h101, 1'b0, "wrap.fill1");
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1, 96'h102 + DW'(k), 1'b1, $sformatf("wrap%0d", k));
      cmp($sformatf("wrap%0d.count2", k), DW'(count), DW'(2));
      cmp($sformatf("wrap%0d.head", k), out_data, 96'h101 + DW'(k));
    end

    // Mid-stream asynchronous reset at count 3.
    applyStimulus(1'b1, 96'h200, 1'b0, "pre_rst");
    cmp("pre_rst.count3", DW'(count), DW'(3));
    in_valid = 1'b0;
    pulseReset();

    // Duplicate handling.
    applyStimulus(1'b1, recA, 1'b0, "dupA0");
    applyStimulus(1'b1, recA, 1'b0, "dupA1");
    applyStimulus(1'b1, recA, 1'b0, "dupA2");
    applyStimulus(1'b1, recB, 1'b0, "dupB");
`ifdef STRUCT_STREAM_FIFO_DEDUP_EN
    cmp("dedup.count", DW'(count),    DW'(2));
    cmp("dedup.drop",  DW'(drop_cnt), DW'(2));
    for (int k = 0; k < 300; k++) applyStimulus(1'b1, recB, 1'b0, "dupBrep");
    cmp("dedup.sat",   DW'(drop_cnt), DW'(255));
    cmp("dedup.count_sat", DW'(count), DW'(2));
`else
    cmp("nodedup.count4", DW'(count),    DW'(4));
    cmp("nodedup.drop4",  DW'(drop_cnt), DW'(0));
    in_valid = 1'b0;
    pulseReset();
    applyStimulus(1'b1, recA, 1'b0, "nodupA0");
    applyStimulus(1'b1, recA, 1'b0, "nodupA1");
    cmp("nodedup.count", DW'(count),    DW'(2));
    cmp("nodedup.drop",  DW'(drop_cnt), DW'(0));
`endif
    in_valid = 1'b0;
    pulseReset();

    // Random traffic from a small pool so repeats and full/empty are frequent.
    pool[0] = recA;
    pool[1] = recC;
    pool[2] = {$urandom, $urandom, $urandom};
    pool[3] = {$urandom, $urandom, $urandom};
    for (int k = 0; k < 500; k++) begin
      logic [DW-1:0] d;
      d = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom, $urandom}
                                      : pool[$urandom_range(0, 3)];
      applyStimulus(1'($urandom_range(0, 1)), d, ($urandom_range(0, 2) != 0),
                    $sformatf("rnd%0d", k));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/struct_stream_fifo.md
STRUCT_STREAM_FIFO -- requirements
Module: struct_stream_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 96: width of the packed record carried, >= 2.
REQ-002 SHALL have parameter DEPTH, default 4: number of storage entries, a power of two, >= 2.
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1: producer offers in_data this cycle.
REQ-006 SHALL have port in_data, input, DATA_W: packed record, bit DATA_W-1 is MSB of first struct member.
REQ-007 SHALL have port in_ready, output, 1: FIFO accepts a record this cycle.
REQ-008 SHALL have port out_valid, output, 1: out_data holds the head record.
REQ-009 SHALL have port out_data, output, DATA_W: head record.
REQ-010 SHALL have port out_ready, input, 1: consumer takes the head this cycle.
REQ-011 SHALL have port count, output, $clog2(DEPTH)+1: stored entries.
REQ-012 SHALL have port drop_cnt, output, 8: suppressed-duplicate counter.

Function
REQ-013 SHALL push on in_valid && in_ready, pop on out_valid && out_ready; both evaluated in the same edge.
REQ-014 SHALL drive in_ready = (count < DEPTH), registered-state only; no combinational path from out_ready.
REQ-015 SHALL drive out_valid = (count != 0) and out_data = storage[rd_ptr] when non-empty, all-zeros when empty.
REQ-016 SHALL make a record pushed into an empty FIFO visible on out_valid/out_data the cycle after the push edge (latency 1).
REQ-017 SHALL, on simultaneous push and pop, keep count unchanged; when count == DEPTH no push occurs since in_ready is 0.
REQ-018 SHALL advance wr_ptr/rd_ptr modulo DEPTH, wrapping DEPTH-1 -> 0 without loss or reorder.
REQ-019 SHALL preserve every bit of the record, including the MSB and LSB of each packed member, unaltered.
REQ-020 SHALL track state EMPTY (count 0), PARTIAL, FULL (count DEPTH); transitions only by +1 push, -1 pop, or hold.
REQ-021 SHALL never underflow: pop with count 0 is impossible since out_valid is 0.

Reset
REQ-022 SHALL on rst_n low, immediately and asynchronously: count 0, pointers 0, out_valid 0, out_data 0, in_ready 1, drop_cnt 0, dedup history invalid.
REQ-023 SHALL discard all stored records when reset asserts mid-stream; storage contents need not be cleared.
REQ-024 SHALL resume normal operation on the first rising clk edge after rst_n deasserts.

Configuration
REQ-025 SHALL, with macro STRUCT_STREAM_FIFO_DEDUP_EN defined, keep a last-pushed register plus valid flag; a handshake whose in_data equals the last pushed record is accepted (in_ready as normal) but not stored, and drop_cnt increments, saturating at 255.
REQ-026 SHALL, with the dedup macro defined, compare only against the last record actually stored, independent of pops; history valid flag set on first push.
REQ-027 SHALL, without STRUCT_STREAM_FIFO_DEDUP_EN, store every accepted record and tie drop_cnt to 0.

Verification (DATA_W=96, DEPTH=4)
REQ-028 SHALL check: push 0x8000...0001 into empty, out_ready=0 -> next cycle out_valid=1, out_data=0x8000...0001, count=1.
REQ-029 SHALL check: push 4 distinct records, out_ready=0 -> count=4, in_ready=0; 5th in_valid ignored; drain yields the 4 in order.
REQ-030 SHALL check: count=2, in_valid and out_ready high for 10 cycles with increasing data -> count stays 2, pointers wrap, output order matches input.
REQ-031 SHALL check: count=3, pulse rst_n low between edges -> outputs zero and in_ready=1 at once, before next clk edge.
REQ-032 SHALL check with dedup defined: push A, A, A, B -> count=2, drop_cnt=2; 300 repeats of B -> drop_cnt=255.
REQ-033 SHALL check without dedup: push A, A -> count=2, drop_cnt=0.
